// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator instruction sequencer: opcodes,
// FSM state encoding and the decoded control bundle.
package ac_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int OPC_W_DEF  = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_IN  = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_WAIT_IN = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    // carry_upd is internal: the execute cycle latches ALU carry into the flag
    typedef struct packed {
        logic jump;
        logic jumpc;
        logic sin;
        logic ina;
        logic twone;
        logic ac_load;
        logic carry_upd;
    } ctl_t;

endpackage

// File: rtl/ac_decode.sv
// Combinational opcode decoder producing the execute-cycle control bundle.
module ac_decode
    import ac_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opcode,
    output ctl_t             ctl
);

    always_comb begin
        ctl = '0;
        case (opcode)
            OPC_W'(OP_LDA): begin
                ctl.ina     = 1'b1;
                ctl.ac_load = 1'b1;
            end
            OPC_W'(OP_ADD): begin
                ctl.twone     = 1'b1;
                ctl.ac_load   = 1'b1;
                ctl.carry_upd = 1'b1;
            end
            OPC_W'(OP_SUB): begin
                ctl.twone     = 1'b1;
                ctl.ina       = 1'b1;
                ctl.ac_load   = 1'b1;
                ctl.carry_upd = 1'b1;
            end
            OPC_W'(OP_IN): begin
                ctl.sin     = 1'b1;
                ctl.ac_load = 1'b1;
            end
            OPC_W'(OP_JMP): ctl.jump  = 1'b1;
            OPC_W'(OP_JC):  ctl.jumpc = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ac_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the accumulator control
// strobes, program counter and instruction register.
module ac_sequencer
    import ac_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data,
    input  logic              in_valid,
    output logic              in_ack,
    input  logic              carry,
    output logic [7-OPC_W:0]  operand,
    output logic              jump,
    output logic              jumpC,
    output logic              sin,
    output logic              InA,
    output logic              twone,
    output logic              ac_load,
    output logic              halted
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [7:0]        ir, ir_nxt;
    logic              carry_flag, carry_flag_nxt;
    logic [OPC_W-1:0]  opc;
    ctl_t              dec, ctl;
    logic              rd_c, ack_c, halt_c;

    assign opc     = ir[7 -: OPC_W];
    assign operand = ir[7-OPC_W:0];

    ac_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode (opc),
        .ctl    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            carry_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ir         <= ir_nxt;
            carry_flag <= carry_flag_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ir_nxt         = ir;
        carry_flag_nxt = carry_flag;
        ctl            = '0;
        rd_c           = 1'b0;
        ack_c          = 1'b0;
        halt_c         = 1'b0;
        case (state)
            S_FETCH: begin
                rd_c = 1'b1;
                if (mem_ready) begin
                    ir_nxt    = mem_data;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == OPC_W'(OP_IN))
                    state_nxt = S_WAIT_IN;
                else if (opc == OPC_W'(OP_HLT))
                    state_nxt = S_HALT;
                else
                    state_nxt = S_EXEC;
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    ack_c     = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                ctl       = dec;
                state_nxt = S_FETCH;
                if (dec.jump)
                    pc_nxt = ADDR_W'(operand);
                // a taken JC consumes the flag; clearing a zero flag is harmless
                if (dec.jumpc) begin
                    if (carry_flag)
                        pc_nxt = ADDR_W'(operand);
                    carry_flag_nxt = 1'b0;
                end
                if (dec.carry_upd)
                    carry_flag_nxt = carry;
            end
            S_HALT:  halt_c = 1'b1;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, whatever the old state.
    assign mem_addr = pc;
    assign mem_rd   = rd_c & ~reset;
    assign in_ack   = ack_c & ~reset;
    assign halted   = halt_c & ~reset;
    assign jump     = ctl.jump & ~reset;
    assign jumpC    = ctl.jumpc & ~reset;
    assign sin      = ctl.sin & ~reset;
    assign InA      = ctl.ina & ~reset;
    assign twone    = ctl.twone & ~reset;
    assign ac_load  = ctl.ac_load & ~reset;

endmodule

// File: tb/tb_ac_sequencer.sv
// Scoreboard bench for ac_sequencer: an instruction-level program interpreter
// predicts fetch addresses and strobe events; a monitor checks the DUT.
module tb_ac_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic       mem_ready = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ack;
    logic       carry = 1'b0;
    logic [3:0] operand;
    logic       jump, jumpC, sin, InA, twone, ac_load, halted;

    ac_sequencer #(.ADDR_W(4), .OPC_W(4)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data), .in_valid(in_valid),
        .in_ack(in_ack), .carry(carry), .operand(operand), .jump(jump),
        .jumpC(jumpC), .sin(sin), .InA(InA), .twone(twone),
        .ac_load(ac_load), .halted(halted)
    );

    always #5 clk = ~clk;

    // event vector layout {jump, jumpC, sin, InA, twone, ac_load, in_ack}
    localparam logic [6:0] E_JMP = 7'b1000000;
    localparam logic [6:0] E_JC  = 7'b0100000;
    localparam logic [6:0] E_SIN = 7'b0010000;
    localparam logic [6:0] E_INA = 7'b0001000;
    localparam logic [6:0] E_TW  = 7'b0000100;
    localparam logic [6:0] E_LD  = 7'b0000010;
    localparam logic [6:0] E_ACK = 7'b0000001;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t       addr_q[$];
    exp_t       ev_q[$];
    logic [7:0] prog[16];
    bit         carry_seq[64];
    int         ncmp = 0;
    int         nfail = 0;
    int         cyc = 0;
    bit         armed = 1'b0;
    bit         exp_halt = 1'b0;
    int         final_pc = 0;
    int         rdy_mode = 0;
    int         ivd = 0;
    int         hs_idx = 0;
    int         hs_limit = 1000;
    int         wcnt = 0;
    int         dly_cur = 0;
    int         since_hs = 100;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) cyc <= 1;
        else       cyc <= cyc + 1;
    end

    // memory / input / carry driver, updates shortly after each rising edge
    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            since_hs  = 100;
            in_valid  = 1'b0;
        end else begin
            since_hs++;
            mem_ready = 1'b0;
            if (mem_rd && hs_idx < hs_limit) begin
                if (wcnt >= dly_cur) begin
                    mem_ready = 1'b1;
                    carry     = carry_seq[hs_idx % 64];
                    hs_idx++;
                    since_hs  = 0;
                    wcnt      = 0;
                    dly_cur   = (rdy_mode < 0) ? int'($urandom_range(0, 3)) : rdy_mode;
                end else begin
                    wcnt++;
                end
            end
            mem_data = prog[mem_addr];
            in_valid = (ivd < 0) ? 1'($urandom_range(0, 1)) : (since_hs >= ivd);
        end
    end

    // monitor: pops the scoreboard whenever the DUT fetches or strobes
    logic       prev_rd = 1'b0;
    logic [3:0] prev_addr = '0;
    always @(negedge clk) begin
        logic [6:0] v;
        exp_t       e;
        if (!armed || reset) begin
            prev_rd = 1'b0;
        end else begin
            v = {jump, jumpC, sin, InA, twone, ac_load, in_ack};
            if (v[6:4] != 3'b000)
                chk("strobe_exclusive", $countones(v[6:4]), 1);
            if (prev_rd && mem_rd)
                chk("addr_stable", mem_addr, prev_addr);
            if (mem_rd && mem_ready) begin
                if (addr_q.size() == 0) begin
                    chk("fetch_unexpected", mem_addr, -1);
                end else begin
                    e = addr_q.pop_front();
                    chk("fetch_addr", mem_addr, e.val);
                    if (e.cyc >= 0) chk("fetch_cycle", cyc, e.cyc);
                end
            end
            if (v != '0) begin
                if (ev_q.size() == 0) begin
                    chk("strobe_unexpected", v, 0);
                end else begin
                    e = ev_q.pop_front();
                    chk("strobes", v, e.val);
                    if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
                end
            end
            prev_rd   = mem_rd;
            prev_addr = mem_addr;
        end
    end

    // Instruction-level interpreter. Timing is predicted only for fixed memory
    // delay: fetch, decode, execute, plus wait cycles for memory and input.
    task automatic build(input int n, input int dly, input int ivw, input bit timed);
        int pc = 0;
        bit cf = 1'b0;
        int t = 1;
        int fa, ex, ack, opd;
        logic [7:0] ins;
        logic [3:0] op;
        exp_halt = 1'b0;
        for (int k = 0; k < n; k++) begin
            fa = t + dly;
            addr_q.push_back('{pc, timed ? fa : -1});
            ins = prog[pc];
            op  = ins[7:4];
            opd = int'(ins[3:0]);
            pc  = (pc + 1) % 16;
            if (op == 4'hF) begin
                exp_halt = 1'b1;
                final_pc = pc;
                return;
            end
            ex = fa + 2;
            case (op)
                4'h1: ev_q.push_back('{int'(E_INA | E_LD), timed ? ex : -1});
                4'h2: begin
                    ev_q.push_back('{int'(E_TW | E_LD), timed ? ex : -1});
                    cf = carry_seq[k];
                end
                4'h3: begin
                    ev_q.push_back('{int'(E_TW | E_INA | E_LD), timed ? ex : -1});
                    cf = carry_seq[k];
                end
                4'h4: begin
                    ack = fa + 2 + ((ivw > 2) ? ivw - 2 : 0);
                    ex  = ack + 1;
                    ev_q.push_back('{int'(E_ACK), timed ? ack : -1});
                    ev_q.push_back('{int'(E_SIN | E_LD), timed ? ex : -1});
                end
                4'h6: begin
                    ev_q.push_back('{int'(E_JMP), timed ? ex : -1});
                    pc = opd;
                end
                4'h7: begin
                    ev_q.push_back('{int'(E_JC), timed ? ex : -1});
                    if (cf) pc = opd;
                    cf = 1'b0;
                end
                default: ;
            endcase
            t = ex + 1;
        end
        addr_q.push_back('{pc, timed ? t + dly : -1});
    endtask

    task automatic do_reset(input bit arm);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        armed   = 1'b0;
        hs_idx  = 0;
        dly_cur = (rdy_mode < 0) ? int'($urandom_range(0, 3)) : rdy_mode;
        @(negedge clk);
        chk("reset_outputs", {mem_rd, jump, jumpC, sin, InA, twone, ac_load, in_ack, halted}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        armed = arm;
        @(negedge clk);
        chk("reset_pc", mem_addr, 0);
        chk("reset_mem_rd", mem_rd, 1);
        chk("reset_halted", halted, 0);
        chk("reset_strobes", {jump, jumpC, sin, InA, twone, ac_load, in_ack}, 0);
    endtask

    task automatic run(input string tag, input int n, input int rmode, input int ivmode,
                       input bit timed, input int budget);
        int i;
        rdy_mode = rmode;
        ivd      = ivmode;
        hs_limit = 1000;
        addr_q.delete();
        ev_q.delete();
        build(n, rmode, ivmode, timed);
        do_reset(1'b1);
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (addr_q.size() == 0 && ev_q.size() == 0 && (!exp_halt || halted)) break;
        end
        chk({tag, "_completed"}, int'(i < budget), 1);
        if (exp_halt) begin
            repeat (3) @(negedge clk);
            chk({tag, "_halted"}, halted, 1);
            chk({tag, "_halt_mem_rd"}, mem_rd, 0);
            chk({tag, "_halt_pc"}, mem_addr, final_pc);
        end
        armed = 1'b0;
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 16; a++) prog[a] = 8'h00;
        for (int k = 0; k < 64; k++) carry_seq[k] = 1'b0;
    endtask

    logic [3:0] op_tab[12];
    logic [3:0] op_pick;

    initial begin
        op_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'h2, 4'h7};

        // LDA, ADD, HLT with zero-wait memory, then with 2 wait cycles per fetch
        clear_prog();
        prog[0] = 8'h11; prog[1] = 8'h23; prog[2] = 8'hF0;
        run("basic", 10, 0, 0, 1'b1, 100);
        run("mem_wait2", 10, 2, 0, 1'b1, 100);

        // JC taken and not taken after ADD
        clear_prog();
        prog[0] = 8'h22; prog[1] = 8'h79; prog[2] = 8'hF0; prog[9] = 8'hF0;
        carry_seq[0] = 1'b1;
        run("jc_taken", 10, 0, 0, 1'b1, 100);
        carry_seq[0] = 1'b0;
        run("jc_not_taken", 10, 0, 0, 1'b1, 100);

        // jumps around the top address, and plain wrap 15 -> 0
        clear_prog();
        prog[0] = 8'h6F; prog[15] = 8'h66; prog[6] = 8'hF0;
        run("jmp_at_15", 10, 0, 0, 1'b1, 100);
        prog[15] = 8'h00;
        run("wrap_15", 4, 0, 0, 1'b1, 100);

        // IN with input held off for four wait cycles
        clear_prog();
        prog[0] = 8'h40; prog[1] = 8'hF0;
        run("in_wait4", 10, 0, 6, 1'b1, 100);

        // randomized programs, memory latency and input availability
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) begin
                op_pick = op_tab[$urandom_range(0, 11)];
                prog[a] = {op_pick, 4'($urandom)};
            end
            for (int k = 0; k < 64; k++) carry_seq[k] = 1'($urandom);
            run("random", 25, -1, -1, 1'b0, 1500);
        end

        // reset while stalled in WAIT_IN
        clear_prog();
        prog[0] = 8'h40;
        rdy_mode = 0;
        ivd = 100000;
        hs_limit = 1000;
        do_reset(1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("wait_in_quiet", {jump, jumpC, sin, InA, twone, ac_load, in_ack}, 0);
        end
        chk("wait_in_mem_rd", mem_rd, 0);
        chk("wait_in_pc", mem_addr, 1);
        do_reset(1'b0);

        // reset while a fetch is pending
        clear_prog();
        ivd = 0;
        hs_limit = 2;
        do_reset(1'b0);
        repeat (12) @(negedge clk);
        chk("pending_mem_rd", mem_rd, 1);
        chk("pending_pc", mem_addr, 2);
        do_reset(1'b0);
        hs_limit = 1000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared so far", ncmp);
        $fatal(1, "watchdog");
    end

endmodule
